// File: rtl/axi_inf_write_state_core.sv
// AXI4 write-burst engine: takes a burst request, issues one AW, streams the
// requested number of beats from a first-word-fall-through FIFO onto W, then
// collects the B response and reports it back to the requester.
module axi_inf_write_state_core #(
  parameter int IDSIZE    = 4,
  parameter int ID        = 0,
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256
) (
  input  logic                     axi_aclk,
  input  logic                     rst,
  // Request side
  input  logic                     write_req,
  input  logic [LSIZE-1:0]         req_len,
  input  logic [ASIZE-1:0]         req_addr,
  output logic                     req_resp,
  output logic                     req_done,
  output logic                     resp_err,
  input  logic                     pend_in,
  output logic                     pend_out,
  // FWFT FIFO
  input  logic [AXI_DSIZE-1:0]     fifo_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  // AW channel
  output logic [IDSIZE-1:0]        axi_awid,
  output logic [ASIZE-1:0]         axi_awaddr,
  output logic [LSIZE-1:0]         axi_awlen,
  output logic [2:0]               axi_awsize,
  output logic [1:0]               axi_awburst,
  output logic                     axi_awlock,
  output logic [3:0]               axi_awcache,
  output logic [2:0]               axi_awprot,
  output logic [3:0]               axi_awqos,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  // W channel
  output logic [AXI_DSIZE-1:0]     axi_wdata,
  output logic [AXI_DSIZE/8-1:0]   axi_wstrb,
  output logic                     axi_wlast,
  output logic                     axi_wvalid,
  input  logic                     axi_wready,
  // B channel
  input  logic [IDSIZE-1:0]        axi_bid,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  output logic                     axi_bready
);

  localparam logic [2:0]        AW_SIZE = 3'($clog2(AXI_DSIZE / 8));
  localparam logic [IDSIZE-1:0] ID_VAL  = IDSIZE'(ID);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] awaddr_q, awaddr_d;
  logic [LSIZE-1:0] awlen_q, awlen_d;
  logic [LSIZE-1:0] cnt_q, cnt_d;
  logic             awvalid_q, awvalid_d;
  logic             req_resp_q, req_resp_d;
  logic             req_done_q, req_done_d;
  logic             resp_err_q, resp_err_d;
  logic             w_hs;

  // Fixed AW attributes: full-width INCR bursts, modifiable/bufferable cache.
  assign axi_awid    = ID_VAL;
  assign axi_awsize  = AW_SIZE;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0011;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;

  // W follows the FIFO head directly; the FWFT FIFO keeps valid stable until popped.
  assign axi_wdata  = fifo_data;
  assign axi_wstrb  = '1;
  assign axi_wvalid = (state_q == S_DATA) && !fifo_empty;
  assign axi_wlast  = axi_wvalid && (cnt_q == awlen_q);
  assign w_hs       = axi_wvalid && axi_wready;
  assign fifo_rd_en = w_hs;

  assign axi_bready = (state_q == S_RESP);
  assign pend_out   = (state_q != S_IDLE);
  assign req_resp   = req_resp_q;
  assign req_done   = req_done_q;
  assign resp_err   = resp_err_q;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    cnt_d      = cnt_q;
    awvalid_d  = awvalid_q;
    req_resp_d = 1'b0;
    req_done_d = 1'b0;
    resp_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (write_req && !pend_in && (req_len != '0)) begin
          awaddr_d   = req_addr;
          awlen_d    = req_len - LSIZE'(1);
          awvalid_d  = 1'b1;
          req_resp_d = 1'b1;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + LSIZE'(1);
          if (axi_wlast) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (axi_bvalid) begin
          req_done_d = 1'b1;
          resp_err_d = (axi_bresp != 2'b00) || (axi_bid != ID_VAL);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any burst straight back to idle.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      cnt_q      <= '0;
      awvalid_q  <= 1'b0;
      req_resp_q <= 1'b0;
      req_done_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      cnt_q      <= cnt_d;
      awvalid_q  <= awvalid_d;
      req_resp_q <= req_resp_d;
      req_done_q <= req_done_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_axi_inf_write_state_core.sv
// Randomized bench for the AXI write-burst engine: a behavioural slave and
// FIFO model checks every cycle of each burst against the burst-level rules.
module tb_axi_inf_write_state_core;

  localparam int IDSIZE    = 4;
  localparam int ID        = 3;
  localparam int ASIZE     = 29;
  localparam int LSIZE     = 9;
  localparam int AXI_DSIZE = 256;

  logic                   axi_aclk = 1'b0;
  logic                   rst;
  logic                   write_req;
  logic [LSIZE-1:0]       req_len;
  logic [ASIZE-1:0]       req_addr;
  logic                   req_resp, req_done, resp_err;
  logic                   pend_in, pend_out;
  logic [AXI_DSIZE-1:0]   fifo_data;
  logic                   fifo_empty, fifo_rd_en;
  logic [IDSIZE-1:0]      axi_awid;
  logic [ASIZE-1:0]       axi_awaddr;
  logic [LSIZE-1:0]       axi_awlen;
  logic [2:0]             axi_awsize;
  logic [1:0]             axi_awburst;
  logic                   axi_awlock;
  logic [3:0]             axi_awcache;
  logic [2:0]             axi_awprot;
  logic [3:0]             axi_awqos;
  logic                   axi_awvalid, axi_awready;
  logic [AXI_DSIZE-1:0]   axi_wdata;
  logic [AXI_DSIZE/8-1:0] axi_wstrb;
  logic                   axi_wlast, axi_wvalid, axi_wready;
  logic [IDSIZE-1:0]      axi_bid;
  logic [1:0]             axi_bresp;
  logic                   axi_bvalid, axi_bready;

  int checks = 0;
  int errors = 0;
  logic [AXI_DSIZE-1:0] fifo_q[$];
  bit pop_pending = 0;

  axi_inf_write_state_core #(
    .IDSIZE(IDSIZE), .ID(ID), .ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(AXI_DSIZE)
  ) dut (
    .axi_aclk(axi_aclk), .rst(rst),
    .write_req(write_req), .req_len(req_len), .req_addr(req_addr),
    .req_resp(req_resp), .req_done(req_done), .resp_err(resp_err),
    .pend_in(pend_in), .pend_out(pend_out),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
    .axi_awcache(axi_awcache), .axi_awprot(axi_awprot), .axi_awqos(axi_awqos),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  // Free-running clock.
  always #5 axi_aclk = ~axi_aclk;

  task automatic idle_inputs();
    write_req   = 1'b0;
    pend_in     = 1'b0;
    req_len     = '0;
    req_addr    = '0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bid     = '0;
    axi_bresp   = 2'b00;
    fifo_empty  = 1'b1;
    fifo_data   = '0;
  endtask

  // Applies last cycle's pop, then presents the FIFO head (optionally held empty).
  task automatic fifo_update(input bit force_empty);
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 0;
    fifo_empty  = force_empty || (fifo_q.size() == 0);
    fifo_data   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  function automatic logic [AXI_DSIZE-1:0] rand_word();
    logic [AXI_DSIZE-1:0] w;
    for (int i = 0; i < AXI_DSIZE / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One complete request/burst/response, checked every cycle against burst-level rules.
  task automatic do_burst(input string name, input int len, input logic [ASIZE-1:0] addr,
                          input int aw_delay, input int wr_mode, input int stall_after,
                          input int stall_cycles, input int b_delay, input logic [1:0] bresp,
                          input logic [IDSIZE-1:0] bid, input int pend_cycles,
                          input int rst_after, input bit contig);
    logic [AXI_DSIZE-1:0] exp_words[$];
    logic [AXI_DSIZE-1:0] w;
    int cyc = 0, aw_cycles = 0, beats = 0, pops = 0, b_wait = 0, stall_left = stall_cycles;
    int first_cyc = -1, last_cyc = -1;
    bit in_data = 0, last_done = 0, b_hs = 0, done = 0;
    bit resp_next = 1, done_next = 0, err_next = 0, stall, exp_wv, exp_last;
    for (int i = 0; i < len; i++) begin
      w = rand_word();
      fifo_q.push_back(w);
      exp_words.push_back(w);
    end
    for (int p = 0; p < pend_cycles; p++) begin
      @(negedge axi_aclk);
      fifo_update(1'b0);
      write_req = 1'b1; pend_in = 1'b1; req_len = LSIZE'(len); req_addr = addr;
      #1;
      checks++;
      if ({req_resp, pend_out, axi_awvalid} !== 3'b000)
        $display("[TB] FAIL %s pend_hold: resp/pend/awvalid=%b expected 000", name,
                 {req_resp, pend_out, axi_awvalid});
      if ({req_resp, pend_out, axi_awvalid} !== 3'b000) errors++;
    end
    @(negedge axi_aclk);
    fifo_update(1'b0);
    write_req = 1'b1; pend_in = 1'b0; req_len = LSIZE'(len); req_addr = addr;
    #1;
    checks++;
    if ({pend_out, axi_awvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL %s accept_cycle: pend/awvalid=%b expected 00", name, {pend_out, axi_awvalid});
    end
    while (!done && cyc < 2000) begin
      @(negedge axi_aclk);
      cyc++;
      write_req = 1'b0;
      stall = in_data && (beats == stall_after) && (stall_left > 0);
      if (stall) stall_left--;
      fifo_update(stall);
      if (rst_after >= 0 && in_data && beats == rst_after) begin
        rst = 1'b1;
        @(negedge axi_aclk);
        #1;
        checks++;
        if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, fifo_rd_en, req_resp, req_done,
             resp_err, pend_out, axi_awaddr, axi_awlen} !== '0) begin
          errors++;
          $display("[TB] FAIL %s reset_abort: outputs not cleared (pend=%b awv=%b wv=%b awaddr=%h)",
                   name, pend_out, axi_awvalid, axi_wvalid, axi_awaddr);
        end
        rst = 1'b0;
        fifo_q.delete();
        pop_pending = 0;
        idle_inputs();
        return;
      end
      axi_awready = (aw_cycles >= aw_delay);
      axi_wready  = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      axi_bvalid  = last_done && !b_hs && (b_wait >= b_delay);
      axi_bresp   = bresp;
      axi_bid     = bid;
      if (last_done && !b_hs) b_wait++;
      #1;
      checks++;
      if (req_resp !== resp_next) begin
        errors++;
        $display("[TB] FAIL %s req_resp cyc%0d: got %b expected %b", name, cyc, req_resp, resp_next);
      end
      resp_next = 0;
      checks++;
      if ({req_done, resp_err} !== {done_next, err_next}) begin
        errors++;
        $display("[TB] FAIL %s done/err cyc%0d: got %b%b expected %b%b", name, cyc,
                 req_done, resp_err, done_next, err_next);
      end
      checks++;
      if (pend_out !== !done_next) begin
        errors++;
        $display("[TB] FAIL %s pend_out cyc%0d: got %b expected %b", name, cyc, pend_out, !done_next);
      end
      checks++;
      if (axi_awvalid !== (!in_data && !done_next)) begin
        errors++;
        $display("[TB] FAIL %s awvalid cyc%0d: got %b expected %b", name, cyc, axi_awvalid,
                 !in_data && !done_next);
      end
      if (axi_awvalid) begin
        checks++;
        if (axi_awaddr !== addr || axi_awlen !== LSIZE'(len - 1)) begin
          errors++;
          $display("[TB] FAIL %s aw_fields: addr=%h len=%0d expected addr=%h len=%0d", name,
                   axi_awaddr, axi_awlen, addr, len - 1);
        end
      end
      exp_wv   = in_data && !last_done && !fifo_empty;
      exp_last = exp_wv && (beats == len - 1);
      checks++;
      if ({axi_wvalid, axi_wlast} !== {exp_wv, exp_last}) begin
        errors++;
        $display("[TB] FAIL %s wvalid/wlast cyc%0d beat%0d: got %b%b expected %b%b", name, cyc,
                 beats, axi_wvalid, axi_wlast, exp_wv, exp_last);
      end
      if (exp_wv) begin
        checks++;
        if (axi_wdata !== exp_words[beats]) begin
          errors++;
          $display("[TB] FAIL %s wdata beat%0d: got %h expected %h", name, beats,
                   axi_wdata[63:0], exp_words[beats][63:0]);
        end
      end
      checks++;
      if (fifo_rd_en !== (exp_wv && axi_wready)) begin
        errors++;
        $display("[TB] FAIL %s fifo_rd_en cyc%0d: got %b expected %b", name, cyc, fifo_rd_en,
                 exp_wv && axi_wready);
      end
      checks++;
      if (axi_bready !== (last_done && !b_hs)) begin
        errors++;
        $display("[TB] FAIL %s bready cyc%0d: got %b expected %b", name, cyc, axi_bready,
                 last_done && !b_hs);
      end
      if (done_next) done = 1;
      done_next = 0; err_next = 0;
      if (axi_awvalid) aw_cycles++;
      if (axi_awvalid && axi_awready) in_data = 1;
      if (axi_wvalid && axi_wready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
        if (beats == len) last_done = 1;
      end
      if (fifo_rd_en) begin
        pops++;
        pop_pending = 1;
      end
      if (axi_bvalid && axi_bready) begin
        b_hs      = 1;
        done_next = 1;
        err_next  = (bresp != 2'b00) || (bid != IDSIZE'(ID));
      end
    end
    axi_bvalid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s timeout: req_done not seen within %0d cycles", name, cyc);
    end
    checks++;
    if (pops != len || beats != len) begin
      errors++;
      $display("[TB] FAIL %s beat_count: pops=%0d beats=%0d expected %0d", name, pops, beats, len);
    end
    checks++;
    if (aw_cycles != aw_delay + 1) begin
      errors++;
      $display("[TB] FAIL %s aw_hold: awvalid cycles=%0d expected %0d", name, aw_cycles, aw_delay + 1);
    end
    if (contig) begin
      checks++;
      if (last_cyc - first_cyc != len - 1) begin
        errors++;
        $display("[TB] FAIL %s contiguous: beat span=%0d expected %0d", name,
                 last_cyc - first_cyc, len - 1);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge axi_aclk);
    #1;
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_wlast, axi_bready, fifo_rd_en, req_resp, req_done,
         resp_err, pend_out, axi_awaddr, axi_awlen} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: pend=%b awv=%b wv=%b awaddr=%h awlen=%0d", pend_out,
               axi_awvalid, axi_wvalid, axi_awaddr, axi_awlen);
    end
    checks++;
    if ({axi_awid, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos} !==
        {4'd3, 3'd5, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000} || axi_wstrb !== {(AXI_DSIZE/8){1'b1}}) begin
      errors++;
      $display("[TB] FAIL aw_constants: id=%0d size=%0d burst=%b cache=%b strb_ok=%b", axi_awid,
               axi_awsize, axi_awburst, axi_awcache, axi_wstrb === {(AXI_DSIZE/8){1'b1}});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_burst("basic16", 16, 29'h1000, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 0, -1, 1);
  endtask

  task automatic test_aw_delay();
    do_burst("aw_delay", 8, 29'h2040, 5, 0, -1, 0, 1, 2'b00, 4'(ID), 0, -1, 1);
  endtask

  task automatic test_fifo_stall();
    do_burst("fifo_stall", 4, 29'h3000, 0, 1, 2, 3, 2, 2'b00, 4'(ID), 0, -1, 0);
  endtask

  task automatic test_single();
    do_burst("single", 1, 29'h0400, 1, 0, -1, 0, 0, 2'b00, 4'(ID), 0, -1, 1);
  endtask

  task automatic test_resp_err();
    do_burst("slverr", 3, 29'h0800, 0, 0, -1, 0, 1, 2'b10, 4'(ID), 0, -1, 1);
    do_burst("bad_bid", 2, 29'h0820, 0, 0, -1, 0, 0, 2'b00, 4'd5, 0, -1, 1);
  endtask

  task automatic test_pend_in();
    do_burst("pend_in", 5, 29'h5000, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 4, -1, 1);
  endtask

  task automatic test_len_zero();
    for (int i = 0; i < 4; i++) begin
      @(negedge axi_aclk);
      write_req = 1'b1; pend_in = 1'b0; req_len = '0; req_addr = 29'h1234;
      #1;
      checks++;
      if ({req_resp, pend_out, axi_awvalid} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL len_zero cyc%0d: resp/pend/awvalid=%b expected 000", i,
                 {req_resp, pend_out, axi_awvalid});
      end
    end
    write_req = 1'b0;
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(1, 24);
      do_burst("random", len, ASIZE'($urandom) & ~ASIZE'(31), $urandom_range(0, 3), 2,
               $urandom_range(0, len - 1), $urandom_range(0, 3), $urandom_range(0, 3),
               2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(ID),
               $urandom_range(0, 2), -1, 0);
    end
  endtask

  task automatic test_back_to_back();
    do_burst("b2b_a", 6, 29'h6000, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 0, -1, 1);
    do_burst("b2b_b", 7, 29'h60C0, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 0, -1, 1);
  endtask

  task automatic test_reset_mid_burst();
    do_burst("rst_mid", 10, 29'h7000, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 0, 3, 0);
    do_burst("after_rst", 3, 29'h7100, 0, 0, -1, 0, 0, 2'b00, 4'(ID), 0, -1, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_fifo_stall();
    test_single();
    test_resp_err();
    test_pend_in();
    test_len_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
